// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared mode encodings and default widths for the display source selector
// Contents: disp_mode_e (manual / auto-scan / freeze / reserved), default word and mask widths.
package disp_pkg;

    typedef enum logic [1:0] {
        DISP_MANUAL = 2'd0,
        DISP_AUTO   = 2'd1,
        DISP_FREEZE = 2'd2,
        DISP_RSVD   = 2'd3
    } disp_mode_e;

    localparam int DISP_DATA_W = 32;
    localparam int DISP_MASK_W = 4;

endpackage

// File: rtl/scan_next_idx.sv
// rtl/scan_next_idx.sv - combinational search for the next enabled display source after cur_sel
// Ports:
//   cur_sel  in   SEL_W    index currently shown
//   src_en   in   NUM_SRC  per-source include mask
//   next_idx out  SEL_W    first enabled index above cur_sel, wrapping modulo NUM_SRC
//   none_en  out  1        no source enabled; next_idx then equals cur_sel
module scan_next_idx #(
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]   cur_sel,
    input  logic [NUM_SRC-1:0] src_en,
    output logic [SEL_W-1:0]   next_idx,
    output logic               none_en
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        next_idx = cur_sel;
        none_en  = ~|src_en;
        cand     = '0;
        // Walk farthest offset first so the nearest enabled index wins. Offset
        // NUM_SRC lands back on cur_sel, which covers the single-enabled case.
        // The modulo also folds an out-of-range cur_sel left by manual mode.
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = SEL_W'((int'(cur_sel) + k) % NUM_SRC);
            if (src_en[cand]) begin
                next_idx = cand;
            end
        end
    end

endmodule

// File: rtl/disp_src_scan_sel.sv
// rtl/disp_src_scan_sel.sv - registered N-way display source selector with auto-scan, freeze and blink phase
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   EN                  global update enable; all state holds while low
//   mode                0 manual, 1 auto-scan, 2 freeze, 3 treated as manual
//   Disp_sel            manual source index
//   src_en              per-source include mask for auto-scan
//   Disp_in/point_in/blink_in  packed per-source word and masks, source i at [i*W +: W]
//   Disp_num/point_out/blink_out  registered selection
//   blink_phase         square wave, half-period BLINK_HALF cycles
//   cur_sel             index driving the outputs
//   sel_chg             one-cycle pulse after cur_sel changes
module disp_src_scan_sel
    import disp_pkg::*;
#(
    parameter  int NUM_SRC      = 8,
    parameter  int DATA_W       = DISP_DATA_W,
    parameter  int MASK_W       = DISP_MASK_W,
    parameter  int DWELL_CYCLES = 50000000,
    parameter  int BLINK_HALF   = 25000000,
    localparam int SEL_W        = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      EN,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          Disp_sel,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*DATA_W-1:0] Disp_in,
    input  logic [NUM_SRC*MASK_W-1:0] point_in,
    input  logic [NUM_SRC*MASK_W-1:0] blink_in,
    output logic [DATA_W-1:0]         Disp_num,
    output logic [MASK_W-1:0]         point_out,
    output logic [MASK_W-1:0]         blink_out,
    output logic                      blink_phase,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_chg
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [DATA_W-1:0] disp_arr  [NUM_SRC];
    logic [MASK_W-1:0] point_arr [NUM_SRC];
    logic [MASK_W-1:0] blink_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign disp_arr[i]  = Disp_in[i*DATA_W +: DATA_W];
        assign point_arr[i] = point_in[i*MASK_W +: MASK_W];
        assign blink_arr[i] = blink_in[i*MASK_W +: MASK_W];
    end

    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_nxt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [SEL_W-1:0]   scan_idx;
    logic               none_en;
    logic               load;
    logic               in_range;
    logic               dwell_wrap;
    logic               blink_wrap;

    scan_next_idx #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_scan_next_idx (
        .cur_sel  (cur_sel),
        .src_en   (src_en),
        .next_idx (scan_idx),
        .none_en  (none_en)
    );

    assign dwell_wrap = (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_HALF - 1));

    always_comb begin
        sel_nxt   = cur_sel;
        dwell_nxt = dwell_cnt;
        load      = 1'b1;
        case (disp_mode_e'(mode))
            DISP_AUTO: begin
                if (dwell_wrap) begin
                    dwell_nxt = '0;
                    if (!none_en) begin
                        sel_nxt = scan_idx;
                    end
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            DISP_FREEZE: begin
                load = 1'b0;
            end
            default: begin
                // Holding the dwell count at 0 here makes a later switch to
                // auto-scan start a full dwell period from the current index.
                sel_nxt   = Disp_sel;
                dwell_nxt = '0;
            end
        endcase
        in_range = (int'(sel_nxt) < NUM_SRC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Disp_num    <= '0;
            point_out   <= '0;
            blink_out   <= '0;
            blink_phase <= 1'b0;
            cur_sel     <= '0;
            sel_chg     <= 1'b0;
            dwell_cnt   <= '0;
            blink_cnt   <= '0;
        end else if (EN) begin
            cur_sel   <= sel_nxt;
            dwell_cnt <= dwell_nxt;
            sel_chg   <= (sel_nxt != cur_sel);
            if (load) begin
                Disp_num  <= in_range ? disp_arr[sel_nxt]  : '0;
                point_out <= in_range ? point_arr[sel_nxt] : '0;
                blink_out <= in_range ? blink_arr[sel_nxt] : '0;
            end
            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            sel_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_src_scan_sel.sv
// tb/tb_disp_src_scan_sel.sv - randomized and directed self-checking bench for disp_src_scan_sel
module tb_disp_src_scan_sel;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int DWL = 4;
    localparam int BLH = 3;
    localparam int N5  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [1:0]      mode;
    logic [2:0]      disp_sel;
    logic [N-1:0]    src_en;
    logic [N*DW-1:0] disp_in;
    logic [N*MW-1:0] point_in;
    logic [N*MW-1:0] blink_in;
    logic [DW-1:0]   disp_num;
    logic [MW-1:0]   point_out;
    logic [MW-1:0]   blink_out;
    logic            blink_phase;
    logic [2:0]      cur_sel;
    logic            sel_chg;

    logic [1:0]       d5_mode;
    logic [2:0]       d5_sel;
    logic [N5-1:0]    d5_src_en;
    logic [N5*DW-1:0] d5_disp;
    logic [N5*MW-1:0] d5_point;
    logic [N5*MW-1:0] d5_blink;
    logic [DW-1:0]    d5_num;
    logic [MW-1:0]    d5_pout;
    logic [MW-1:0]    d5_bout;
    logic             d5_phase;
    logic [2:0]       d5_cur;
    logic             d5_chg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: what the outputs must be after the latest edge.
    logic [2:0]    m_sel;
    int            m_dwell, m_bcnt;
    logic          m_phase, m_chg;
    logic [DW-1:0] m_num;
    logic [MW-1:0] m_point, m_blink;

    always #5 clk = ~clk;

    disp_src_scan_sel #(
        .NUM_SRC(N), .DATA_W(DW), .MASK_W(MW), .DWELL_CYCLES(DWL), .BLINK_HALF(BLH)
    ) u_dut (
        .clk(clk), .rst(rst), .EN(en), .mode(mode), .Disp_sel(disp_sel), .src_en(src_en),
        .Disp_in(disp_in), .point_in(point_in), .blink_in(blink_in),
        .Disp_num(disp_num), .point_out(point_out), .blink_out(blink_out),
        .blink_phase(blink_phase), .cur_sel(cur_sel), .sel_chg(sel_chg)
    );

    disp_src_scan_sel #(
        .NUM_SRC(N5), .DATA_W(DW), .MASK_W(MW), .DWELL_CYCLES(DWL), .BLINK_HALF(BLH)
    ) u_dut5 (
        .clk(clk), .rst(rst), .EN(en), .mode(d5_mode), .Disp_sel(d5_sel), .src_en(d5_src_en),
        .Disp_in(d5_disp), .point_in(d5_point), .blink_in(d5_blink),
        .Disp_num(d5_num), .point_out(d5_pout), .blink_out(d5_bout),
        .blink_phase(d5_phase), .cur_sel(d5_cur), .sel_chg(d5_chg)
    );

    // Applies one clock edge of the behavioural rules to the model using the
    // inputs presently driven.
    task automatic model_step();
        int ns;
        if (rst) begin
            m_sel = 0; m_dwell = 0; m_bcnt = 0; m_phase = 0; m_chg = 0;
            m_num = 0; m_point = 0; m_blink = 0;
        end else if (!en) begin
            m_chg = 0;
        end else begin
            ns = int'(m_sel);
            if (mode == 2'd1) begin
                if (m_dwell == DWL - 1) begin
                    m_dwell = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (src_en[(int'(m_sel) + k) % N]) begin
                            ns = (int'(m_sel) + k) % N;
                            break;
                        end
                    end
                end else begin
                    m_dwell = m_dwell + 1;
                end
            end else if (mode != 2'd2) begin
                ns = int'(disp_sel);
                m_dwell = 0;
            end
            if (mode != 2'd2) begin
                m_num   = disp_in[ns*DW +: DW];
                m_point = point_in[ns*MW +: MW];
                m_blink = blink_in[ns*MW +: MW];
            end
            m_chg = (ns != int'(m_sel));
            m_sel = 3'(ns);
            if (m_bcnt == BLH - 1) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end else begin
                m_bcnt = m_bcnt + 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 2'd1; disp_sel = 3'd7; src_en = '1;
        disp_in = {N{32'h5A5A_1234}}; point_in = '1; blink_in = '1;
        tick(); tick();
        tests_run++; if (disp_num !== 32'h0) begin tests_failed++; $display("FAIL reset_num got %h want 0", disp_num); end
        tests_run++; if (point_out !== 4'h0) begin tests_failed++; $display("FAIL reset_point got %h want 0", point_out); end
        tests_run++; if (blink_out !== 4'h0) begin tests_failed++; $display("FAIL reset_blink got %h want 0", blink_out); end
        tests_run++; if (blink_phase !== 1'b0) begin tests_failed++; $display("FAIL reset_phase got %b want 0", blink_phase); end
        tests_run++; if (cur_sel !== 3'd0) begin tests_failed++; $display("FAIL reset_sel got %0d want 0", cur_sel); end
        tests_run++; if (sel_chg !== 1'b0) begin tests_failed++; $display("FAIL reset_chg got %b want 0", sel_chg); end
        rst = 0; mode = 2'd0; disp_sel = 3'd3; disp_in[3*DW +: DW] = 32'hDEADBEEF;
        tick();
        tests_run++; if (disp_num !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL first_num got %h want deadbeef", disp_num); end
        tests_run++; if (cur_sel !== 3'd3) begin tests_failed++; $display("FAIL first_sel got %0d want 3", cur_sel); end
        tests_run++; if (sel_chg !== 1'b1) begin tests_failed++; $display("FAIL first_chg got %b want 1", sel_chg); end
        tick();
        tests_run++; if (sel_chg !== 1'b0) begin tests_failed++; $display("FAIL first_chg_once got %b want 0", sel_chg); end
    endtask

    task automatic test_en_hold();
        disp_sel = 3'd5; point_in[5*MW +: MW] = 4'hA; blink_in[5*MW +: MW] = 4'h3; en = 0;
        repeat (3) begin
            tick();
            tests_run++; if (point_out !== 4'hF || cur_sel !== 3'd3) begin
                tests_failed++; $display("FAIL en_hold got point %h sel %0d want f 3", point_out, cur_sel);
            end
            tests_run++; if (sel_chg !== 1'b0) begin tests_failed++; $display("FAIL en_hold_chg got %b want 0", sel_chg); end
        end
        en = 1;
        tick();
        tests_run++; if (point_out !== 4'hA || blink_out !== 4'h3) begin
            tests_failed++; $display("FAIL en_load got point %h blink %h want a 3", point_out, blink_out);
        end
        tests_run++; if (cur_sel !== 3'd5 || sel_chg !== 1'b1) begin
            tests_failed++; $display("FAIL en_load_sel got %0d/%b want 5/1", cur_sel, sel_chg);
        end
    endtask

    task automatic test_auto_seq();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd2; exp_seq[1] = 3'd5; exp_seq[2] = 3'd7; exp_seq[3] = 3'd2;
        disp_sel = 3'd0; tick(); tick();
        mode = 2'd1; src_en = 8'b1010_0100;
        for (int c = 1; c <= 16; c++) begin
            for (int i = 0; i < N; i++) disp_in[i*DW +: DW] = $urandom;
            tick();
            if (c % 4 == 0) begin
                tests_run++; if (cur_sel !== exp_seq[c/4-1] || sel_chg !== 1'b1) begin
                    tests_failed++; $display("FAIL auto_seq c=%0d got %0d/%b want %0d/1", c, cur_sel, sel_chg, exp_seq[c/4-1]);
                end
            end else begin
                tests_run++; if (sel_chg !== 1'b0) begin tests_failed++; $display("FAIL auto_chg c=%0d got 1 want 0", c); end
            end
            tests_run++; if (disp_num !== m_num) begin tests_failed++; $display("FAIL auto_track c=%0d got %h want %h", c, disp_num, m_num); end
        end
    endtask

    task automatic test_auto_none();
        int n;
        src_en = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            tests_run++; if (cur_sel !== 3'd2 || sel_chg !== 1'b0) begin
                tests_failed++; $display("FAIL none_hold c=%0d got %0d/%b want 2/0", c, cur_sel, sel_chg);
            end
        end
        src_en = 8'h40;
        n = 0;
        while (cur_sel == 3'd2 && n < 8) begin
            tick(); n++;
        end
        tests_run++; if (cur_sel !== 3'd6 || n != 4) begin
            tests_failed++; $display("FAIL none_resume got sel %0d after %0d want 6 after 4", cur_sel, n);
        end
    endtask

    task automatic test_freeze();
        logic [DW-1:0] held, fresh;
        logic [2:0]    sel_h;
        logic          last_ph;
        int            toggles;
        held = disp_num; sel_h = cur_sel; last_ph = blink_phase; toggles = 0;
        mode = 2'd2;
        for (int c = 0; c < 12; c++) begin
            disp_in[int'(sel_h)*DW +: DW] = $urandom;
            tick();
            tests_run++; if (disp_num !== held || cur_sel !== sel_h) begin
                tests_failed++; $display("FAIL freeze_hold got %h/%0d want %h/%0d", disp_num, cur_sel, held, sel_h);
            end
            tests_run++; if (blink_phase !== m_phase) begin tests_failed++; $display("FAIL freeze_phase got %b want %b", blink_phase, m_phase); end
            if (blink_phase != last_ph) toggles++;
            last_ph = blink_phase;
        end
        tests_run++; if (toggles != 4) begin tests_failed++; $display("FAIL freeze_toggles got %0d want 4", toggles); end
        mode = 2'd0; disp_sel = sel_h; fresh = $urandom; disp_in[int'(sel_h)*DW +: DW] = fresh;
        tick();
        tests_run++; if (disp_num !== fresh) begin tests_failed++; $display("FAIL unfreeze got %h want %h", disp_num, fresh); end
    endtask

    task automatic test_reset_mid_scan();
        disp_sel = 3'd5; tick();
        mode = 2'd1; src_en = 8'b1010_0100; tick(); tick();
        rst = 1; tick();
        tests_run++; if (cur_sel !== 3'd0 || disp_num !== 32'h0 || blink_phase !== 1'b0 || sel_chg !== 1'b0) begin
            tests_failed++; $display("FAIL mid_rst got %0d %h %b %b want 0 0 0 0", cur_sel, disp_num, blink_phase, sel_chg);
        end
        rst = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            tests_run++; if (cur_sel !== ((c == 4) ? 3'd2 : 3'd0)) begin
                tests_failed++; $display("FAIL mid_resume c=%0d got %0d want %0d", c, cur_sel, (c == 4) ? 2 : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 31) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) disp_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) src_en = 8'($urandom);
            for (int i = 0; i < N; i++) disp_in[i*DW +: DW] = $urandom;
            point_in = $urandom; blink_in = $urandom;
            tick();
            tests_run++; if (cur_sel !== m_sel || sel_chg !== m_chg) begin
                tests_failed++; $display("FAIL rnd_sel c=%0d got %0d/%b want %0d/%b", c, cur_sel, sel_chg, m_sel, m_chg);
            end
            tests_run++; if (disp_num !== m_num || point_out !== m_point || blink_out !== m_blink) begin
                tests_failed++; $display("FAIL rnd_data c=%0d got %h %h %h want %h %h %h", c, disp_num, point_out, blink_out, m_num, m_point, m_blink);
            end
            tests_run++; if (blink_phase !== m_phase) begin tests_failed++; $display("FAIL rnd_phase c=%0d got %b want %b", c, blink_phase, m_phase); end
        end
    endtask

    task automatic test_non_pow2();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd0;
        rst = 0; en = 1; d5_mode = 2'd0; d5_sel = 3'd6;
        for (int i = 0; i < N5; i++) d5_disp[i*DW +: DW] = $urandom | 32'h1;
        d5_point = '1; d5_blink = '1;
        tick();
        tests_run++; if (d5_num !== 32'h0 || d5_pout !== 4'h0 || d5_cur !== 3'd6) begin
            tests_failed++; $display("FAIL oor_sel got %h %h %0d want 0 0 6", d5_num, d5_pout, d5_cur);
        end
        d5_sel = 3'd4; tick();
        tests_run++; if (d5_num !== d5_disp[4*DW +: DW] || d5_cur !== 3'd4) begin
            tests_failed++; $display("FAIL top_src got %h/%0d want %h/4", d5_num, d5_cur, d5_disp[4*DW +: DW]);
        end
        d5_sel = 3'd6; tick();
        d5_mode = 2'd1; d5_src_en = 5'b00011;
        for (int w = 0; w < 3; w++) begin
            repeat (4) tick();
            tests_run++; if (d5_cur !== exp_seq[w] || d5_num !== d5_disp[int'(exp_seq[w])*DW +: DW]) begin
                tests_failed++; $display("FAIL np2_scan w=%0d got %0d/%h want %0d", w, d5_cur, d5_num, exp_seq[w]);
            end
        end
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; disp_sel = 0; src_en = 0; disp_in = 0; point_in = 0; blink_in = 0;
        d5_mode = 0; d5_sel = 0; d5_src_en = 0; d5_disp = 0; d5_point = 0; d5_blink = 0;
        m_sel = 0; m_dwell = 0; m_bcnt = 0; m_phase = 0; m_chg = 0; m_num = 0; m_point = 0; m_blink = 0;
        test_reset();
        test_en_hold();
        test_auto_seq();
        test_auto_none();
        test_freeze();
        test_reset_mid_scan();
        test_random();
        test_non_pow2();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
